im_loader: RTL and testbench

Runtime writer for the 4096×16 instruction memory, the write-side counterpart of the instruction fetch port. It receives a framed byte stream from the host link over a valid/ready handshake and assembles little-endian 16-bit words. It writes them into the code region (words 0–2047) or dictionary region (words 2048–4095) through the memory write port. While a frame is in progress it holds the processor so that no fetch observes a partially loaded image.

---
 rtl/im_loader_if.sv | 22 ++
 rtl/im_loader.sv | 123 ++++++++++++
 tb/tb_im_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// Bus interfaces for im_loader: the host byte stream (valid/ready) and the
// instruction-memory write port.

interface byte_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

interface im_wr_if #(
  parameter int AW = 12
);
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [15:0]   im_wdata;

  modport master (output im_we, output im_waddr, output im_wdata);
  modport slave  (input  im_we, input  im_waddr, input  im_wdata);
endinterface

// File: rtl/im_loader.sv
// Runtime instruction-memory loader: parses framed host bytes into 16-bit
// little-endian words, writes them to memory and stalls the CPU meanwhile.

module im_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         AW        = 12
) (
  input  logic     clk,
  input  logic     rst_n,
  byte_if.slave    bi,
  im_wr_if.master  wr,
  output logic     cpu_hold,
  output logic     done,
  output logic     err
);

  typedef enum logic [3:0] {
    IDLE, S_ALO, S_AHI, S_CLO, S_CHI, S_DLO, S_DHI, S_CSUM, DONE
  } state_t;

  state_t        state, state_nx;
  logic          accept;
  logic [7:0]    lo_q;
  logic [7:0]    sum_q;
  logic [15:0]   cnt_q;
  logic [AW-1:0] waddr_q;
  logic [15:0]   addr_full;

  assign accept    = bi.in_valid && bi.in_ready;
  assign addr_full = {bi.in_data, lo_q};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept && bi.in_data == SYNC_BYTE) state_nx = S_ALO;
      S_ALO:  if (accept) state_nx = S_AHI;
      S_AHI:  if (accept) state_nx = S_CLO;
      S_CLO:  if (accept) state_nx = S_CHI;
      S_CHI:  if (accept) state_nx = ({bi.in_data, cnt_q[7:0]} != 16'd0) ? S_DLO : S_CSUM;
      S_DLO:  if (accept) state_nx = S_DHI;
      // cnt_q still holds the words remaining including the one being completed
      S_DHI:  if (accept) state_nx = (cnt_q == 16'd1) ? S_CSUM : S_DLO;
      S_CSUM: if (accept) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bi.in_ready <= 1'b0;
      cpu_hold    <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      bi.in_ready <= (state_nx != DONE);
      cpu_hold    <= (state_nx != IDLE);
      done        <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q        <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      waddr_q     <= '0;
      err         <= 1'b0;
      wr.im_we    <= 1'b0;
      wr.im_waddr <= '0;
      wr.im_wdata <= '0;
    end else begin
      wr.im_we <= 1'b0;
      if (accept) begin
        unique case (state)
          IDLE: begin
            if (bi.in_data == SYNC_BYTE) begin
              sum_q <= '0;
              err   <= 1'b0;
            end
          end
          S_ALO: begin
            lo_q  <= bi.in_data;
            sum_q <= sum_q + bi.in_data;
          end
          S_AHI: begin
            // byte address bit 0 and bits above AW are dropped
            waddr_q <= addr_full[AW:1];
            sum_q   <= sum_q + bi.in_data;
          end
          S_CLO: begin
            cnt_q[7:0] <= bi.in_data;
            sum_q      <= sum_q + bi.in_data;
          end
          S_CHI: begin
            cnt_q[15:8] <= bi.in_data;
            sum_q       <= sum_q + bi.in_data;
          end
          S_DLO: begin
            lo_q  <= bi.in_data;
            sum_q <= sum_q + bi.in_data;
          end
          S_DHI: begin
            wr.im_we    <= 1'b1;
            wr.im_waddr <= waddr_q;
            wr.im_wdata <= {bi.in_data, lo_q};
            waddr_q     <= waddr_q + 1'b1;
            cnt_q       <= cnt_q - 16'd1;
            sum_q       <= sum_q + bi.in_data;
          end
          S_CSUM: err <= (bi.in_data != sum_q);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: framed loads, region/wrap addressing,
// checksum error, host stalls with noise, and reset in mid-frame.

module tb_im_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  byte_if          bi ();
  im_wr_if #(12)   wr ();
  logic            cpu_hold, done, err;

  im_loader #(.SYNC_BYTE(8'hA5), .AW(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bi       (bi.slave),
    .wr       (wr.master),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  // Write log, sampled on the falling edge
  logic [11:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic        wh_q[$];

  always @(negedge clk) begin
    if (wr.im_we === 1'b1) begin
      wa_q.push_back(wr.im_waddr);
      wd_q.push_back(wr.im_wdata);
      wh_q.push_back(cpu_hold);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wh_q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bi.in_data  = b;
    bi.in_valid = 1'b1;
    while (bi.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    bi.in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int max_gap);
    foreach (s[i]) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(s[i]);
    end
  endtask

  // At the falling edge right after CSUM: DONE cycle, then one cycle later idle
  task automatic check_done(input string tag, input logic exp_err);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_hold_done"}, 32'(cpu_hold), 32'd1);
    check({tag, "_ready_done"}, 32'(bi.in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_hold_low"}, 32'(cpu_hold), 32'd0);
    check({tag, "_ready_back"}, 32'(bi.in_ready), 32'd1);
  endtask

  logic [7:0] seq[$];

  initial begin
    bi.in_data  = 8'h00;
    bi.in_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bi.in_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_we", 32'(wr.im_we), 32'd0);
    check("rst_waddr", 32'(wr.im_waddr), 32'd0);
    check("rst_wdata", 32'(wr.im_wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bi.in_ready), 32'd1);

    // Basic load: checksum 02+34+12+78+56 = 0x116 -> 0x16
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
    send_seq(seq, 0);
    check("basic_nwr", 32'(wa_q.size()), 32'd2);
    check("basic_a0", 32'(wa_q[0]), 32'd0);
    check("basic_d0", 32'(wd_q[0]), 32'h1234);
    check("basic_a1", 32'(wa_q[1]), 32'd1);
    check("basic_d1", 32'(wd_q[1]), 32'h5678);
    check("basic_hold_we", 32'(wh_q[1]), 32'd1);
    check_done("basic", 1'b0);

    // Dictionary region, odd byte address 0x1001 -> word 2048; sum = 0xBF
    clear_log();
    seq = '{8'hA5, 8'h01, 8'h10, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hBF};
    send_seq(seq, 0);
    check("dict_nwr", 32'(wa_q.size()), 32'd1);
    check("dict_a0", 32'(wa_q[0]), 32'd2048);
    check("dict_d0", 32'(wd_q[0]), 32'hBEEF);
    check_done("dict", 1'b0);

    // Wrap: byte address 0x1FFE -> word 4095, then word 0; sum = 0xC9
    clear_log();
    seq = '{8'hA5, 8'hFE, 8'h1F, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC9};
    send_seq(seq, 0);
    check("wrap_nwr", 32'(wa_q.size()), 32'd2);
    check("wrap_a0", 32'(wa_q[0]), 32'd4095);
    check("wrap_d0", 32'(wd_q[0]), 32'h2211);
    check("wrap_a1", 32'(wa_q[1]), 32'd0);
    check("wrap_d1", 32'(wd_q[1]), 32'h4433);
    check_done("wrap", 1'b0);

    // Zero count, bad checksum (sum 0, sent 1)
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send_seq(seq, 0);
    check("zero_nwr", 32'(wa_q.size()), 32'd0);
    check_done("zero", 1'b1);
    check("err_sticky", 32'(err), 32'd1);

    // Noise before SYNC, then the basic frame with random stalls
    clear_log();
    send_byte(8'h00);
    check("noise0_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'h55);
    check("noise1_hold", 32'(cpu_hold), 32'd0);
    check("noise_err_kept", 32'(err), 32'd1);
    send_byte(8'hA5);
    check("sync_err_clr", 32'(err), 32'd0);
    check("sync_hold", 32'(cpu_hold), 32'd1);
    seq = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    send_seq(seq, 5);
    repeat (3) @(negedge clk);
    check("stall_hold", 32'(cpu_hold), 32'd1);
    check("stall_done_wait", 32'(done), 32'd0);
    send_byte(8'h16);
    check("stall_nwr", 32'(wa_q.size()), 32'd2);
    check("stall_a0", 32'(wa_q[0]), 32'd0);
    check("stall_d0", 32'(wd_q[0]), 32'h1234);
    check("stall_a1", 32'(wa_q[1]), 32'd1);
    check("stall_d1", 32'(wd_q[1]), 32'h5678);
    check_done("stall", 1'b0);

    // Reset after DATA_LO of word 0
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h34};
    send_seq(seq, 0);
    check("pre_rst_hold", 32'(cpu_hold), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_we", 32'(wr.im_we), 32'd0);
    check("midrst_ready", 32'(bi.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_nwr", 32'(wa_q.size()), 32'd0);

    // Fresh frame after release loads normally
    seq = '{8'hA5, 8'h01, 8'h10, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hBF};
    send_seq(seq, 0);
    check("post_rst_nwr", 32'(wa_q.size()), 32'd1);
    check("post_rst_a0", 32'(wa_q[0]), 32'd2048);
    check("post_rst_d0", 32'(wd_q[0]), 32'hBEEF);
    check_done("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
